// File: rtl/fft_reorder_256_pkg.sv
// Shared FFT package: default frame geometry and sample width, plus the
// bit-reverse helper used by the reorder block and the FFT stage blocks.
package fft_reorder_256_pkg;

    localparam int FFT_N    = 256;
    localparam int FFT_LOGN = 8;
    localparam int FFT_DW   = 24;

    // Reverses the low 'bits' bits of a. Bits above 'bits' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned bits);
        logic [31:0] r;
        r = {<<{a}};
        return r >> (32 - bits);
    endfunction

endpackage

// File: rtl/fft_reorder_256_if.sv
// Sample stream bus of the bit-reverse reorder block.
//   in_valid, din_r, din_i          : input samples, bit-reversed order
//   out_valid, dout_r, dout_i       : output samples, natural order
//   out_last                        : high with output index N-1
//   out_idx                         : natural-order index of the output sample
// master = sample source/sink (testbench or upstream), slave = reorder block.
interface fft_reorder_256_if
    import fft_reorder_256_pkg::*;
#(
    parameter int DW   = FFT_DW,
    parameter int LOGN = FFT_LOGN
);

    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;
    logic                 out_last;
    logic [LOGN-1:0]      out_idx;

    modport master (
        output in_valid, din_r, din_i,
        input  out_valid, dout_r, dout_i, out_last, out_idx
    );

    modport slave (
        input  in_valid, din_r, din_i,
        output out_valid, dout_r, dout_i, out_last, out_idx
    );

endinterface

// File: rtl/reorder_bank.sv
// One reorder bank: Depth x W memory, synchronous write, asynchronous read.
// Not reset so it can map onto RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module reorder_bank #(
    parameter int Depth = 256,
    parameter int AW    = 8,
    parameter int W     = 48
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder_256.sv
// Bit-reversed to natural-order reorder buffer for an N-point FFT.
// Two ping-pong banks: one fills at bit-reversed addresses while the other
// is streamed out in natural order, so continuous input gives gap-free output.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sample stream (slave side), see fft_reorder_256_if
module fft_reorder_256
    import fft_reorder_256_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N
) (
    input  logic             clk,
    input  logic             rst_n,
    fft_reorder_256_if.slave bus
);

    localparam int LOGN = $clog2(N);
    localparam int W    = 2 * DW;
    localparam logic [LOGN-1:0] LastIdx = LOGN'(N - 1);

    logic [LOGN-1:0] wr_cnt;
    logic [LOGN-1:0] rd_cnt;
    logic            wr_bank;
    logic            rd_bank;
    logic            rd_active;

    logic [LOGN-1:0] wr_addr;
    logic [W-1:0]    wr_data;
    logic [W-1:0]    rdata0;
    logic [W-1:0]    rdata1;
    logic [W-1:0]    rd_data;
    logic            frame_done;

    logic                 out_valid;
    logic                 out_last;
    logic [LOGN-1:0]      out_idx;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    assign wr_addr    = LOGN'(bitrev(32'(wr_cnt), LOGN));
    assign wr_data    = {bus.din_r, bus.din_i};
    assign frame_done = bus.in_valid && (wr_cnt == LastIdx);
    assign rd_data    = rd_bank ? rdata1 : rdata0;

    reorder_bank #(
        .Depth (N),
        .AW    (LOGN),
        .W     (W)
    ) u_bank0 (
        .clk   (clk),
        .we    (bus.in_valid && !wr_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_cnt),
        .rdata (rdata0)
    );

    reorder_bank #(
        .Depth (N),
        .AW    (LOGN),
        .W     (W)
    ) u_bank1 (
        .clk   (clk),
        .we    (bus.in_valid && wr_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_cnt),
        .rdata (rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_active <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                wr_cnt <= wr_cnt + LOGN'(1);
            end
            // A completed frame takes priority over ending the current read,
            // so back-to-back frames stream out without a bubble.
            if (frame_done) begin
                wr_bank   <= ~wr_bank;
                rd_bank   <= wr_bank;
                rd_active <= 1'b1;
                rd_cnt    <= '0;
            end else if (rd_active) begin
                rd_cnt <= rd_cnt + LOGN'(1);
                if (rd_cnt == LastIdx) begin
                    rd_active <= 1'b0;
                end
            end
        end
    end

    // Data and index only load while reading, so they hold during idle gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else begin
            out_valid <= rd_active;
            out_last  <= rd_active && (rd_cnt == LastIdx);
            if (rd_active) begin
                out_idx <= rd_cnt;
                dout_r  <= rd_data[W-1:DW];
                dout_i  <= rd_data[DW-1:0];
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_idx   = out_idx;
    assign bus.dout_r    = dout_r;
    assign bus.dout_i    = dout_i;

endmodule

// File: tb/tb_fft_reorder_256.sv
module tb_fft_reorder_256;

    localparam int DW   = 24;
    localparam int N    = 256;
    localparam int LOGN = 8;

    typedef struct {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        logic [LOGN-1:0]      idx;
        logic                 last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fft_reorder_256_if #(.DW(DW), .LOGN(LOGN)) bus ();

    fft_reorder_256 #(.DW(DW), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   idx0_cyc = -1;
    int   last_cyc = -1;
    int   run      = 0;
    int   last_run = 0;
    int   n_last   = 0;

    logic signed [DW-1:0] nat_r [N];
    logic signed [DW-1:0] nat_i [N];
    logic signed [DW-1:0] hold_r;
    logic signed [DW-1:0] hold_i;
    logic [LOGN-1:0]      hold_idx;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tb_rev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < LOGN; b++) begin
            if (k[b]) r = r | (1 << (LOGN - 1 - b));
        end
        return r;
    endfunction

    // Scoreboard monitor: pops one expected sample per valid output, and
    // checks that outputs hold (with out_last low) while out_valid is low.
    always @(negedge clk) begin
        if (!rst_n) begin
            run      = 0;
            hold_r   = '0;
            hold_i   = '0;
            hold_idx = '0;
        end else if (bus.out_valid) begin
            run++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output idx=%0d r=%0d i=%0d (no output required)",
                         bus.out_idx, bus.dout_r, bus.dout_i);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.dout_r !== mon_e.r || bus.dout_i !== mon_e.i ||
                    bus.out_idx !== mon_e.idx || bus.out_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL sample got r=%0d i=%0d idx=%0d last=%0b, want r=%0d i=%0d idx=%0d last=%0b",
                             bus.dout_r, bus.dout_i, bus.out_idx, bus.out_last,
                             mon_e.r, mon_e.i, mon_e.idx, mon_e.last);
                end
            end
            if (bus.out_idx == '0) idx0_cyc = cyc;
            if (bus.out_last) begin
                last_cyc = cyc;
                n_last++;
            end
            hold_r   = bus.dout_r;
            hold_i   = bus.dout_i;
            hold_idx = bus.out_idx;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
            checks++;
            if (bus.out_last !== 1'b0 || bus.dout_r !== hold_r || bus.dout_i !== hold_i ||
                bus.out_idx !== hold_idx) begin
                errors++;
                $display("FAIL idle_hold got r=%0d i=%0d idx=%0d last=%0b, want r=%0d i=%0d idx=%0d last=0",
                         bus.dout_r, bus.dout_i, bus.out_idx, bus.out_last,
                         hold_r, hold_i, hold_idx);
            end
        end
    end

    task automatic fill_ramp(input int off);
        for (int n = 0; n < N; n++) begin
            nat_r[n] = DW'(n + off);
            nat_i[n] = DW'(-(n + off));
        end
    endtask

    // Sends nat_* in bit-reversed order. stop_at < N sends a partial frame
    // and pushes no expectations.
    task automatic drive_frame(input int gap, input int stop_at);
        exp_t e;
        if (stop_at >= N) begin
            for (int n = 0; n < N; n++) begin
                e.r    = nat_r[n];
                e.i    = nat_i[n];
                e.idx  = LOGN'(n);
                e.last = (n == N - 1);
                sbq.push_back(e);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (k == stop_at) break;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.din_r    = nat_r[tb_rev(k)];
            bus.din_i    = nat_i[tb_rev(k)];
            acc_cyc      = cyc + 1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_drain();
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0 && !bus.out_valid) break;
        end
        checks++;
        if (sbq.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d out_valid=%0b, want 0 pending and idle",
                     sbq.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_last got %0b want 0", bus.out_last);
        end
        checks++;
        if (bus.dout_r !== '0) begin
            errors++; $display("FAIL reset_dout_r got %0d want 0", bus.dout_r);
        end
        checks++;
        if (bus.dout_i !== '0) begin
            errors++; $display("FAIL reset_dout_i got %0d want 0", bus.dout_i);
        end
        checks++;
        if (bus.out_idx !== '0) begin
            errors++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_timing(input string tag, input int want_run);
        checks++;
        if (idx0_cyc != acc_cyc + 1) begin
            errors++;
            $display("FAIL %s_first_latency got cycle %0d want %0d", tag, idx0_cyc, acc_cyc + 1);
        end
        checks++;
        if (last_cyc != acc_cyc + N) begin
            errors++;
            $display("FAIL %s_last_latency got cycle %0d want %0d", tag, last_cyc, acc_cyc + N);
        end
        checks++;
        if (last_run != want_run) begin
            errors++;
            $display("FAIL %s_valid_run got %0d want %0d", tag, last_run, want_run);
        end
    endtask

    task automatic test_single_frame();
        fill_ramp(0);
        drive_frame(0, N);
        wait_drain();
        check_timing("single", N);
    endtask

    task automatic test_back_to_back();
        n_last = 0;
        for (int f = 0; f < 3; f++) begin
            fill_ramp(1000 * f);
            drive_frame(0, N);
        end
        wait_drain();
        check_timing("b2b", 3 * N);
        checks++;
        if (n_last != 3) begin
            errors++; $display("FAIL b2b_last_count got %0d want 3", n_last);
        end
    endtask

    task automatic test_gapped();
        for (int n = 0; n < N; n++) begin
            nat_r[n] = DW'($urandom);
            nat_i[n] = DW'($urandom);
        end
        drive_frame(2, N);
        wait_drain();
        check_timing("gapped", N);
    endtask

    task automatic test_extremes();
        for (int n = 0; n < N; n++) begin
            nat_r[n] = '0;
            nat_i[n] = '0;
        end
        nat_r[0] = -24'sd8388608;
        nat_i[0] = 24'sd8388607;
        drive_frame(0, N);
        wait_drain();
        check_timing("extremes", N);
    endtask

    task automatic test_reset_mid();
        // Frame 0 completes, so its output is in progress when reset hits
        // partway through frame 1.
        fill_ramp(500);
        drive_frame(0, N);
        fill_ramp(700);
        drive_frame(0, 100);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        sbq.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_async_clear got out_valid=%0b want 0", bus.out_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        fill_ramp(3000);
        drive_frame(0, N);
        wait_drain();
        check_timing("midreset", N);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_extremes();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_reorder_256.md
FFT_REORDER_256 -- requirements
Module: fft_reorder_256

Interface
REQ-001 The block SHALL use the parameter DW, default 24, as the signed width of each real and imaginary sample.
REQ-002 The block SHALL use the parameter N, default 256, as the frame length; N SHALL be a power of two, and LOGN = log2(N) (default 8).
REQ-003 The block SHALL use the reset rst_n, asynchronous, active-low, and the clock clk.
REQ-004 The interface SHALL be, one port per entry (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: din_r/din_i carry a sample this cycle.
- din_r, in, DW signed: real part of the input sample; input samples arrive in bit-reversed order.
- din_i, in, DW signed: imaginary part of the input sample.
- out_valid, out, 1: dout_r/dout_i carry a sample this cycle.
- dout_r, out, DW signed: real part of the output sample; output samples leave in natural order.
- dout_i, out, DW signed: imaginary part of the output sample.
- out_last, out, 1: asserted with output index N-1.
- out_idx, out, LOGN: natural-order index of the current output sample.

Function
REQ-005 The block SHALL contain two banks of N complex entries each (ping-pong).
REQ-006 Write side: a counter wr_cnt (LOGN bits) SHALL increment only on cycles where in_valid=1; the sample SHALL be written to bank[wr_bank][bitrev(wr_cnt)].
REQ-007 bitrev SHALL reverse the LOGN address bits; for N=256, bitrev(1)=128 and bitrev(3)=192.
REQ-008 Gaps in in_valid SHALL be allowed; wr_cnt SHALL hold during gaps.
REQ-009 When a write occurs with wr_cnt=N-1, at that edge: wr_cnt SHALL wrap to 0, wr_bank SHALL toggle, rd_bank SHALL load the old wr_bank, rd_active SHALL set, and rd_cnt SHALL clear to 0.
REQ-010 Read side: while rd_active=1, rd_cnt SHALL increment every cycle, unconditionally (no backpressure).
REQ-011 The read address SHALL be bank[rd_bank][rd_cnt], and the read data SHALL be registered into dout_r/dout_i.
REQ-012 out_valid SHALL be the registered copy of rd_active; out_idx SHALL be the registered copy of rd_cnt; out_last SHALL be registered as (rd_active and rd_cnt=N-1).
REQ-013 After reading rd_cnt=N-1, rd_active SHALL clear, unless REQ-009 fires on the same edge, in which case REQ-009 SHALL win and reading SHALL continue seamlessly from the other bank.
REQ-014 Latency: if the N-th sample of a frame is accepted in cycle T, output index 0 SHALL appear in cycle T+2 and output index N-1 in cycle T+N+1.
REQ-015 With continuous in_valid, output frames SHALL be back-to-back with no out_valid gap and no sample loss.
REQ-016 Sample values SHALL pass through bit-exact, with no arithmetic, scaling or saturation.
REQ-017 A partial frame, where in_valid stops before N samples, SHALL produce no output until it is completed.
REQ-018 While out_valid=0, dout_r, dout_i, out_idx and out_last SHALL hold their previous values, except that out_last SHALL be 0.

Reset
REQ-019 On rst_n=0, the block SHALL asynchronously clear wr_cnt, rd_cnt, wr_bank, rd_bank, rd_active, out_valid, out_last, out_idx, dout_r and dout_i to 0.
REQ-020 Bank memories SHALL NOT be reset, so that they can be inferred as RAM.
REQ-021 A reset asserted mid-frame SHALL discard the partial input frame and any in-progress output; after release, the first accepted sample SHALL be treated as index 0 of a new frame.

Structure
REQ-022 The shared FFT package SHALL hold FFT_N=256, FFT_LOGN=8, FFT_DW=24, and a bit-reverse function used by this block and the stage blocks.
REQ-023 The block SHALL use exactly one sub-module, reorder_bank: an N x 2*DW single-write, single-read memory with a synchronous write and an asynchronous read, instantiated twice.
REQ-024 The block SHALL contain a single clock domain and SHALL have no combinational path from any input to any output.

Verification
REQ-025 Reset check: hold rst_n=0 and toggle clk -> out_valid=0, out_last=0, dout_r=dout_i=0, out_idx=0.
REQ-026 Single frame: drive 256 continuous samples with din_r=bitrev(k) and din_i=-bitrev(k) -> dout_r=0,1,...,255 and dout_i=0,-1,...,-255 in cycles T+2..T+257; out_last is high only at out_idx=255.
REQ-027 Back-to-back: drive 3 continuous frames with offsets 0, 1000 and 2000 -> 768 contiguous out_valid cycles with correct natural-order values and out_last every 256th cycle.
REQ-028 Gapped input: drive in_valid with a 1-in-3 duty cycle for one frame -> output still starts 2 cycles after the 256th accepted sample, and all 256 values are correct.
REQ-029 Extremes: din_r=-8388608 and din_i=8388607 at k=0, zero elsewhere -> output index 0 carries exactly these values, and all other outputs are 0.
REQ-030 Reset mid-operation: assert rst_n=0 at input sample 100 of frame 1, then send a full frame 2 -> no output from frame 1, and frame 2 emerges correct with index 0 first.
